// File: rtl/adder_share_arbiter_pkg.sv
// rtl/adder_share_arbiter_pkg.sv - shared defaults and round-robin pick function
package adder_share_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 64;
  localparam int DEF_ID_W    = 2;
  localparam int MAX_REQ     = 8;
  localparam int PTR_W       = 3;

  // Slots above NUM_REQ are tied low, so a mod-8 search yields the same winner as mod-NUM_REQ.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] g;
    logic [PTR_W-1:0]   idx;
    g = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (valid[idx] && (g == '0)) g[idx] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - request and result handshake bundle
interface adder_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_sum;
  logic [ID_W-1:0]          res_id;
  logic                     res_carry;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_carry
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_id, res_carry
  );
endinterface

// File: rtl/adder_share_arbiter_adder.sv
// rtl/adder_share_arbiter_adder.sv - combinational adder with carry-out
module adder_share_arbiter_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one adder, one-entry result register
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = DEF_ID_W
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_share_arbiter_if.slave bus
);

  logic               w_can_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_any;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr_next;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;

  logic               r_res_valid;
  logic [WIDTH-1:0]   r_res_sum;
  logic               r_res_carry;
  logic [ID_W-1:0]    r_res_id;
  logic [ID_W-1:0]    r_rr_ptr;

  assign w_can_accept = !r_res_valid || bus.res_ready;

  // Grant is held off during reset so no requester sees a handshake it cannot complete.
  assign w_grant = (rst_n && w_can_accept)
                 ? NUM_REQ'(rr_pick(MAX_REQ'(bus.req_valid), PTR_W'(r_rr_ptr)))
                 : '0;
  assign w_grant_any = |w_grant;

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gnt_idx = ID_W'(i);
    end
  end

  assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
  assign w_a        = bus.req_a[w_gnt_idx*WIDTH +: WIDTH];
  assign w_b        = bus.req_b[w_gnt_idx*WIDTH +: WIDTH];

  adder_share_arbiter_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a     (w_a),
    .i_b     (w_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_carry <= 1'b0;
      r_res_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_grant_any) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum;
      r_res_carry <= w_carry;
      r_res_id    <= w_gnt_idx;
      r_rr_ptr    <= w_ptr_next;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.res_valid = r_res_valid;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_carry = r_res_carry;
  assign bus.res_id    = r_res_id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - randomized self-checking bench with a transaction-level reference model
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] tb_valid = '0;
  logic [W-1:0] tb_a [N];
  logic [W-1:0] tb_b [N];
  logic         tb_res_ready = 1'b0;
  logic [N-1:0] pend = '0;

  int           n_checks = 0;
  int           n_errors = 0;

  bit           m_valid;
  logic [W-1:0] m_sum;
  logic         m_carry;
  int           m_id;
  int           m_ptr;

  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) bus ();

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb begin
    bus.req_valid = tb_valid;
    bus.res_ready = tb_res_ready;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = tb_a[i];
      bus.req_b[i*W +: W] = tb_b[i];
    end
  end

  function automatic int exp_pick();
    if (!rst_n) return -1;
    if (m_valid && !tb_res_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (tb_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_sum   = '0;
    m_carry = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  task automatic tick();
    int g;
    g = exp_pick();
    if (g >= 0) begin
      {m_carry, m_sum} = {1'b0, tb_a[g]} + {1'b0, tb_b[g]};
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
      pend[g] = 1'b0;
    end else if (tb_res_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      tb_a[i] = W'(i + 1);
      tb_b[i] = W'(10 * i);
    end
    tb_valid     = '1;
    tb_res_ready = 1'b1;
    rst_n        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    end
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid);
    end
    n_checks++;
    if (bus.res_sum !== 64'd0 || bus.res_id !== 2'd0 || bus.res_carry !== 1'b0) begin
      n_errors++; $display("FAIL reset_res_fields: got sum=%h id=%0d carry=%b expected 0", bus.res_sum, bus.res_id, bus.res_carry);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL reset_first_grant: got %b expected 0001", bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_sum !== 64'd1) begin
      n_errors++; $display("FAIL reset_first_result: got v=%b id=%0d sum=%h expected v=1 id=0 sum=1", bus.res_valid, bus.res_id, bus.res_sum);
    end
  endtask

  task automatic test_single_add();
    tb_valid     = 4'b0010;
    tb_a[1]      = 64'd5;
    tb_b[1]      = 64'd7;
    tb_res_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_errors++; $display("FAIL single_grant: got %b expected 0010", bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 64'd12 || bus.res_id !== 2'd1 || bus.res_carry !== 1'b0) begin
      n_errors++; $display("FAIL single_result: got v=%b sum=%0d id=%0d c=%b expected v=1 sum=12 id=1 c=0", bus.res_valid, bus.res_sum, bus.res_id, bus.res_carry);
    end
    tb_valid = '0;
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    tb_valid     = '1;
    tb_res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] || c == 0) begin
          tb_a[i] = {$urandom, $urandom};
          tb_b[i] = {$urandom, $urandom};
        end
      end
      #1;
      n_checks++;
      if (bus.req_ready !== onehot(exp_seq[c]) || onehot(exp_pick()) !== onehot(exp_seq[c])) begin
        n_errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, bus.req_ready, onehot(exp_seq[c]));
      end
      tick();
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(exp_seq[c]) || bus.res_sum !== m_sum || bus.res_carry !== m_carry) begin
        n_errors++; $display("FAIL rr_result[%0d]: got v=%b id=%0d sum=%h expected v=1 id=%0d sum=%h", c, bus.res_valid, bus.res_id, bus.res_sum, exp_seq[c], m_sum);
      end
    end
  endtask

  task automatic test_backpressure();
    tb_valid     = '1;
    tb_res_ready = 1'b1;
    tick();
    tb_res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin
        n_errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0000", c, bus.req_ready);
      end
      tick();
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_sum !== m_sum || bus.res_id !== 2'(m_id) || m_id != 1) begin
        n_errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h expected v=1 id=1 sum=%h", c, bus.res_valid, bus.res_id, bus.res_sum, m_sum);
      end
    end
    tb_res_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_errors++; $display("FAIL bp_release_grant: got %b expected 0100", bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_sum !== tb_a[2] + tb_b[2]) begin
      n_errors++; $display("FAIL bp_release_result: got v=%b id=%0d sum=%h expected v=1 id=2 sum=%h", bus.res_valid, bus.res_id, bus.res_sum, tb_a[2] + tb_b[2]);
    end
    tb_valid = '0;
  endtask

  task automatic test_wrap();
    tb_valid     = 4'b0001;
    tb_a[0]      = 64'hFFFF_FFFF_FFFF_FFFF;
    tb_b[0]      = 64'd1;
    tb_res_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.res_sum !== 64'd0 || bus.res_carry !== 1'b1 || bus.res_id !== 2'd0) begin
      n_errors++; $display("FAIL wrap: got sum=%h carry=%b id=%0d expected sum=0 carry=1 id=0", bus.res_sum, bus.res_carry, bus.res_id);
    end
    tb_valid = '0;
    tick();
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_empty: got %b expected 0", bus.res_valid);
    end
  endtask

  task automatic test_random();
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          tb_a[i] = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
          tb_b[i] = {$urandom, $urandom};
        end
      end
      tb_valid     = pend;
      tb_res_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (bus.req_ready !== onehot(exp_pick())) begin
        n_errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", c, bus.req_ready, onehot(exp_pick()));
      end
      tick();
      n_checks++;
      if (bus.res_valid !== m_valid ||
          (m_valid && (bus.res_sum !== m_sum || bus.res_id !== 2'(m_id) || bus.res_carry !== m_carry))) begin
        n_errors++; $display("FAIL rand_result[%0d]: got v=%b id=%0d sum=%h c=%b expected v=%b id=%0d sum=%h c=%b", c, bus.res_valid, bus.res_id, bus.res_sum, bus.res_carry, m_valid, m_id, m_sum, m_carry);
      end
    end
    tb_valid = '0;
  endtask

  task automatic test_mid_reset();
    tb_valid     = 4'b0100;
    tb_a[2]      = {$urandom, $urandom};
    tb_b[2]      = {$urandom, $urandom};
    tb_res_ready = 1'b1;
    tick();
    tb_valid     = '0;
    tb_res_ready = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2) begin
      n_errors++; $display("FAIL midrst_prefill: got v=%b id=%0d expected v=1 id=2", bus.res_valid, bus.res_id);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.res_sum !== 64'd0 || bus.res_id !== 2'd0) begin
      n_errors++; $display("FAIL midrst_async: got v=%b sum=%h id=%0d expected v=0 sum=0 id=0", bus.res_valid, bus.res_sum, bus.res_id);
    end
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    tb_valid     = '1;
    tb_res_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL midrst_ptr: got %b expected 0001", bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.res_id !== 2'd0 || bus.res_valid !== 1'b1) begin
      n_errors++; $display("FAIL midrst_first_result: got v=%b id=%0d expected v=1 id=0", bus.res_valid, bus.res_id);
    end
    tb_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
